// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the MEM-stage memory access controller
package mem_ctrl_pkg;

  // MEM-stage opcode as presented on req_op
  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  // Load-data extender opcodes; byte/half bases are offset by the lane index
  localparam logic [3:0] EXT_NONE = 4'b0000;
  localparam logic [3:0] EXT_LW   = 4'b0001;
  localparam logic [3:0] EXT_LB   = 4'b0010;
  localparam logic [3:0] EXT_LH   = 4'b0110;
  localparam logic [3:0] EXT_LBU  = 4'b1000;
  localparam logic [3:0] EXT_LHU  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_lane_decode.sv
// rtl/mem_lane_decode.sv - combinational lane decode: byte enables, write replication,
// extender opcode and alignment check for one memory op
module mem_lane_decode
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        we,
  output logic [3:0]  extop,
  output logic        misaligned,
  output logic [31:0] wdata_rep
);

  always_comb begin
    be         = 4'b1111;
    we         = op_is_store(op);
    extop      = EXT_NONE;
    misaligned = 1'b0;
    wdata_rep  = wdata;
    case (op)
      OP_LW: begin
        extop      = EXT_LW;
        misaligned = (addr_lo != 2'b00);
      end
      OP_LB: begin
        extop = EXT_LB + {2'b00, addr_lo};
      end
      OP_LBU: begin
        extop = EXT_LBU + {2'b00, addr_lo};
      end
      OP_LH: begin
        extop      = EXT_LH + {3'b000, addr_lo[1]};
        misaligned = addr_lo[0];
      end
      OP_LHU: begin
        extop      = EXT_LHU + {3'b000, addr_lo[1]};
        misaligned = addr_lo[0];
      end
      OP_SW: begin
        misaligned = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SB: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: begin
        extop = EXT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory sequencer: issues the access, waits for
// a variable-latency ack with timeout, and reports completion with extender opcode
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_word,
  output logic [3:0]  extop,
  output logic        err_align,
  output logic        err_bus,
  output logic        err_store,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ext_pend;

  logic [3:0]  dec_be;
  logic        dec_we;
  logic [3:0]  dec_extop;
  logic        dec_misaligned;
  logic [31:0] dec_wdata;

  mem_lane_decode u_decode (
    .op         (req_op),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (dec_be),
    .we         (dec_we),
    .extop      (dec_extop),
    .misaligned (dec_misaligned),
    .wdata_rep  (dec_wdata)
  );

  // The pipeline is released during the DONE cycle and advances at its end
  assign stall = req_valid && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ext_pend  <= EXT_NONE;
      done      <= 1'b0;
      err_align <= 1'b0;
      err_bus   <= 1'b0;
      err_store <= 1'b0;
      extop     <= EXT_NONE;
      ld_word   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (dec_misaligned) begin
              done      <= 1'b1;
              err_align <= 1'b1;
              err_store <= dec_we;
              extop     <= EXT_NONE;
              state     <= ST_DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= dec_we;
              mem_be    <= dec_be;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= dec_wdata;
              ext_pend  <= dec_extop;
              cnt       <= '0;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // An ack on the final counted cycle still completes without error
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              ld_word <= mem_rdata;
            end
            extop <= ext_pend;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            done      <= 1'b1;
            err_bus   <= 1'b1;
            err_store <= mem_we;
            extop     <= EXT_NONE;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          err_align <= 1'b0;
          err_bus   <= 1'b0;
          err_store <= 1'b0;
          extop     <= EXT_NONE;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
